// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, grant ids,
// SRAM control constants and the SRAM word-address width.
package sram_arb_pkg;

    localparam int SRAM_AW = 20;  // SRAM word address bits, taken from byte address [21:2]
    localparam int CNT_W   = 4;   // access wait counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_e;

    typedef logic gnt_t;
    localparam gnt_t GNT_IF  = 1'b0;
    localparam gnt_t GNT_MEM = 1'b1;

    // Active-low SRAM strobes grouped so they always move together.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } sram_ctrl_t;

    localparam sram_ctrl_t CTRL_IDLE  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
    localparam sram_ctrl_t CTRL_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
    localparam sram_ctrl_t CTRL_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};

    localparam logic [3:0] BE_N_IDLE = 4'hF;  // no byte lanes selected
    localparam logic [3:0] BE_N_ALL  = 4'h0;  // full-word read

    // Strobe pattern held for the whole access.
    function automatic sram_ctrl_t access_ctrl(input logic is_write);
        return is_write ? CTRL_WRITE : CTRL_READ;
    endfunction

endpackage

// File: rtl/sram_arb_perf_cnt.sv
// Free-running 32-bit event counter (wraps, no saturation) used by the
// arbiter's optional performance monitors. The module only exists when
// SRAM_ARB_PERF_EN is defined, matching the only place it is instantiated.
`ifdef SRAM_ARB_PERF_EN
module sram_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    // Count one per cycle with inc_i high; wrap-around is intended.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/sram_arbiter.sv
// Arbiter sharing one asynchronous single-port SRAM between instruction
// fetch (IF) and the MEM-stage load/store port. Fixed priority MEM > IF,
// fixed-length SRAM cycle of WAIT_CYCLES (1..15), one-cycle ack per access.
// All outputs are registered. Optional build macro SRAM_ARB_PERF_EN adds
// the perf_if_wait_o / perf_conflict_o event counters.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    // instruction fetch port
    input  logic               if_req_i,
    input  logic [31:0]        if_addr_i,
    output logic [31:0]        if_rdata_o,
    output logic               if_ack_o,
    // MEM-stage load/store port
    input  logic               mem_re_i,
    input  logic               mem_we_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [3:0]         mem_wbe_n_i,
    input  logic [31:0]        mem_wdata_i,
    output logic [31:0]        mem_rdata_o,
    output logic               mem_ack_o,
`ifdef SRAM_ARB_PERF_EN
    output logic [31:0]        perf_if_wait_o,
    output logic [31:0]        perf_conflict_o,
`endif
    // SRAM pins
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    input  logic [31:0]        sram_rdata_i,
    output logic [3:0]         sram_be_n_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);

    // Counter reload so that ACCESS lasts exactly WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    gnt_t               gnt_q;
    logic               write_q;
    sram_ctrl_t         ctrl_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_n_q;
    logic               if_ack_q;
    logic               mem_ack_q;
    logic [31:0]        if_rdata_q;
    logic [31:0]        mem_rdata_q;

    // Grant candidate, evaluated every cycle but only latched in IDLE.
    logic               mem_req;
    logic               any_req;
    gnt_t               gnt_d;
    logic               write_d;
    logic [SRAM_AW-1:0] addr_d;
    logic [31:0]        wdata_d;
    logic [3:0]         be_n_d;

    assign mem_req = mem_re_i | mem_we_i;
    assign any_req = mem_req | if_req_i;

    // Only word-address bits reach the SRAM; byte offset and upper bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:22], if_addr_i[1:0],
                                mem_addr_i[31:22], mem_addr_i[1:0]};

    // Fixed-priority selection of the operands for the next access (MEM wins).
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        gnt_d   = GNT_IF;
        write_d = 1'b0;
        addr_d  = if_addr_i[21:2];
        wdata_d = '0;
        be_n_d  = BE_N_ALL;
        if (mem_req) begin
            gnt_d   = GNT_MEM;
            write_d = mem_we_i;  // re and we together count as a store
            addr_d  = mem_addr_i[21:2];
            if (mem_we_i) begin
                wdata_d = mem_wdata_i;
                be_n_d  = mem_wbe_n_i;
            end
        end
    end

    // Access FSM with registered SRAM pins, acks and read-data captures.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_IF;
            write_q     <= 1'b0;
            ctrl_q      <= CTRL_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= BE_N_IDLE;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= CNT_LOAD;
                        gnt_q   <= gnt_d;
                        write_q <= write_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        be_n_q  <= be_n_d;
                        ctrl_q  <= access_ctrl(write_d);
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                        ctrl_q  <= CTRL_IDLE;
                        be_n_q  <= BE_N_IDLE;
                        if (!write_q) begin
                            if (gnt_q == GNT_MEM) begin
                                mem_rdata_q <= sram_rdata_i;
                            end else begin
                                if_rdata_q <= sram_rdata_i;
                            end
                        end
                        if_ack_q  <= (gnt_q == GNT_IF);
                        mem_ack_q <= (gnt_q == GNT_MEM);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    // Single-cycle ack; arbitration resumes in the following IDLE cycle.
                    state_q   <= ST_IDLE;
                    if_ack_q  <= 1'b0;
                    mem_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o   = if_rdata_q;
    assign if_ack_o     = if_ack_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign mem_ack_o    = mem_ack_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_be_n_o  = be_n_q;
    assign sram_ce_n_o  = ctrl_q.ce_n;
    assign sram_oe_n_o  = ctrl_q.oe_n;
    assign sram_we_n_o  = ctrl_q.we_n;

`ifdef SRAM_ARB_PERF_EN
    logic if_wait_inc;
    logic conflict_inc;

    assign if_wait_inc  = if_req_i & ~if_ack_q;
    assign conflict_inc = (state_q == ST_IDLE) & if_req_i & mem_req;

    sram_arb_perf_cnt u_perf_if_wait (
        .clk   (clk),
        .rst   (rst),
        .inc_i (if_wait_inc),
        .cnt_o (perf_if_wait_o)
    );

    sram_arb_perf_cnt u_perf_conflict (
        .clk   (clk),
        .rst   (rst),
        .inc_i (conflict_inc),
        .cnt_o (perf_conflict_o)
    );
`endif

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one asynchronous single-port SRAM between the instruction-fetch port and the MEM-stage load/store port. Each access runs a fixed-length SRAM cycle, and each requester gets a one-cycle acknowledge with the read data. The block sits between the IF/MEM stages and the external SRAM pins. A held request acts as that stage's stall condition.

## Interface
- `WAIT_CYCLES`, default 2: cycles the SRAM controls are held per access; legal values 1–15.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `if_req_i`  in  1  fetch request
- `if_addr_i`  in  32  fetch address
- `if_rdata_o`  out  32  fetch data, valid while `if_ack_o`
- `if_ack_o`  out  1  one-cycle fetch-complete pulse
- `mem_re_i` / `mem_we_i`  in  1  load / store request
- `mem_addr_i`  in  32  load/store address
- `mem_wbe_n_i`  in  4  active-low byte enables (store)
- `mem_wdata_i`  in  32  store data
- `mem_rdata_o`  out  32  load word (unaligned extraction stays in MEM), valid while `mem_ack_o`
- `mem_ack_o`  out  1  one-cycle load/store-complete pulse
- `sram_addr_o`  out  20  word address, taken from bits [21:2]
- `sram_wdata_o`  out  32  write data
- `sram_rdata_i`  in  32  read data
- `sram_be_n_o`  out  4  byte enables
- `sram_ce_n_o` / `sram_oe_n_o` / `sram_we_n_o`  out  1  active-low SRAM controls

## Operation
- **FSM states:** IDLE, ACCESS, ACK.
- **IDLE:**
  - Arbitrate; the MEM request is `mem_re_i | mem_we_i`.
  - On a grant: latch the address, write data, byte enables, operation and grant id; load the counter with `WAIT_CYCLES-1`; go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration:** fixed priority, MEM over IF.
- **ACCESS:**
  - `ce_n=0` throughout.
  - Read: `oe_n=0`, `we_n=1`, `be_n=4'b0000`, `wdata` undriven-value 0.
  - Write: `oe_n=1`, `we_n=0`, `be_n` = latched `mem_wbe_n_i`.
  - Counter decrements each cycle.
  - At counter 0:
    - A read captures `sram_rdata_i` into the granted port's rdata register.
    - Go to ACK.
- **ACK:**
  - SRAM controls deasserted.
  - The granted port's ack is 1 for exactly this cycle.
  - Go to IDLE; re-arbitration happens in the next cycle.
- **Handshake:**
  - A requester holds its request and operands stable until it sees ack.
  - It may re-request in the cycle after ack.
  - Dropping a request before ack is illegal. The access still completes and acks.
- **Both `mem_re_i` and `mem_we_i` high:** treated as a write.
- **Store with `mem_wbe_n_i=4'b1111`:** a full SRAM write cycle runs with no bytes enabled, then acks.
- **IF fetches** are always full-word reads.

## Timing
- **Reset values:**
  - State IDLE, counter 0.
  - `if_ack_o=0`, `mem_ack_o=0`.
  - `if_rdata_o=0`, `mem_rdata_o=0`.
  - `sram_addr_o=0`, `sram_wdata_o=0`, `sram_be_n_o=4'hF`.
  - `ce_n=oe_n=we_n=1`.
- **Latency:**
  - Request sampled in IDLE at cycle t.
  - ACCESS in cycles t+1 … t+`WAIT_CYCLES`.
  - Ack in cycle t+`WAIT_CYCLES`+1.
- **Throughput:** one access per `WAIT_CYCLES`+2 cycles.
- **Registered outputs:** all outputs are registered, with no combinational path from request to SRAM pins.
- **Reset mid-access:** IDLE on the next edge. Controls deassert, no ack is issued, and requesters must reissue.
- **Simultaneous requests in IDLE:** MEM is granted; IF waits at least `WAIT_CYCLES`+2 cycles.
- **Counter width:** 4 bits.

## Configuration
- **`SRAM_ARB_PERF_EN` defined:** adds two 32-bit outputs, counting with wrap-around and cleared by `rst`.
  - `perf_if_wait_o`: cycles with `if_req_i` high and no `if_ack_o`.
  - `perf_conflict_o`: IDLE cycles where both ports request.
- **Not defined:** the ports and counters are absent, and the functional behaviour is identical.

## Structure
- **Shared package `sram_arb_pkg`:**
  - State enum (IDLE/ACCESS/ACK).
  - Grant id constants (`GNT_IF`, `GNT_MEM`).
  - SRAM idle-control constants.
  - SRAM address width 20.
- **Sub-module `sram_arb_perf_cnt`:** a saturating-free 32-bit event counter with `clk`/`rst`/`inc_i`/`cnt_o`. It is instantiated twice, only under `SRAM_ARB_PERF_EN`.

## Test plan
- **IF read:** `WAIT_CYCLES=2`, IF read of 0x8000_0010 with the SRAM model returning 0x1234_5678.
  - `sram_addr_o`=0x00004.
  - `oe_n` low for 2 cycles.
  - `if_ack_o` pulses at t+3 with `if_rdata_o`=0x1234_5678.
- **Byte store:** `mem_we_i`, address 0x8000_0003, `mem_wbe_n_i`=4'b0111, wdata 0xAB00_0000.
  - `we_n` low for 2 cycles with `be_n`=0111.
  - Then `mem_ack_o`; only byte 3 of the SRAM model changes.
- **Collision:** IF and MEM load both request in the same cycle.
  - MEM acks at t+3.
  - IF is granted at t+4 and acks at t+7.
- **Back-to-back IF:** IF re-requests in the cycle after ack; it acks every 4 cycles.
- **Reset mid-access:** reset asserted in the second ACCESS cycle.
  - Controls are all 1 on the next cycle.
  - No ack occurs.
  - A new request then completes normally.
- **Perf counters (`SRAM_ARB_PERF_EN`):** run the collision scenario.
  - `perf_conflict_o`=1.
  - `perf_if_wait_o`=7.
